// File: rtl/elevator_ctrl_n_if.sv
// rtl/elevator_ctrl_n_if.sv - request/status bundle between the elevator core and its surroundings
// Optional ELEVATOR_ESTOP_EN adds the ESTOP input and FAULT output to the bundle.
interface elevator_ctrl_n_if #(
   parameter int NUM_FLOORS = 8,
   parameter int FLOOR_W    = 3
);
   logic                  REQ_VALID;
   logic [FLOOR_W-1:0]    REQ_FLOOR;
   logic                  HOLD;
   logic [FLOOR_W-1:0]    FLOOR;
   logic                  DIR_UP;
   logic                  MOVING;
   logic                  DOOR_OPEN;
   logic [NUM_FLOORS-1:0] PENDING;
   logic                  ARRIVED;
`ifdef ELEVATOR_ESTOP_EN
   logic                  ESTOP;
   logic                  FAULT;

   modport master (
      output REQ_VALID, REQ_FLOOR, HOLD, ESTOP,
      input  FLOOR, DIR_UP, MOVING, DOOR_OPEN, PENDING, ARRIVED, FAULT
   );
   modport slave (
      input  REQ_VALID, REQ_FLOOR, HOLD, ESTOP,
      output FLOOR, DIR_UP, MOVING, DOOR_OPEN, PENDING, ARRIVED, FAULT
   );
`else
   modport master (
      output REQ_VALID, REQ_FLOOR, HOLD,
      input  FLOOR, DIR_UP, MOVING, DOOR_OPEN, PENDING, ARRIVED
   );
   modport slave (
      input  REQ_VALID, REQ_FLOOR, HOLD,
      output FLOOR, DIR_UP, MOVING, DOOR_OPEN, PENDING, ARRIVED
   );
`endif
endinterface

// File: rtl/elevator_ctrl_n.sv
// rtl/elevator_ctrl_n.sv - N-floor SCAN elevator controller core with TICK-based travel and door timers
// Optional ELEVATOR_ESTOP_EN: emergency stop freezes motion and timers and raises FAULT.
module elevator_ctrl_n #(
   parameter int NUM_FLOORS = 8,
   parameter int FLOOR_W    = 3,
   parameter int MOVE_TICKS = 4,
   parameter int DOOR_TICKS = 3
) (
   input  logic           CLOCK_50,
   input  logic           RESET,
   input  logic           TICK,
   elevator_ctrl_n_if.slave bus
);
   localparam int TMAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_TICKS - 1);
   localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_TICKS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR} state_t;

   state_t                state_q, state_n;
   logic [FLOOR_W-1:0]    floor_q, floor_n;
   logic                  dir_q, dir_n;
   logic [NUM_FLOORS-1:0] pend_q, pend_n;
   logic [TW-1:0]         move_q, move_n;
   logic [TW-1:0]         door_q, door_n;
   logic                  arr_q, arr_n;
   logic [NUM_FLOORS-1:0] set_mask, clr_mask;
   logic                  tick_en, run, req_ok, same_door, can_step;
   logic [FLOOR_W-1:0]    step_floor;

   function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
      onehot = '0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i == int'(f)) onehot[i] = 1'b1;
   endfunction

   function automatic logic any_side(input logic [NUM_FLOORS-1:0] v,
                                     input logic [FLOOR_W-1:0] f, input logic up);
      any_side = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (v[i] && (up ? (i > int'(f)) : (i < int'(f)))) any_side = 1'b1;
   endfunction

`ifdef ELEVATOR_ESTOP_EN
   logic fault_q;
   assign tick_en = TICK & ~bus.ESTOP;
   assign run     = ~bus.ESTOP;
   always_ff @(posedge CLOCK_50) begin
      if (RESET) fault_q <= 1'b0;
      else       fault_q <= bus.ESTOP;
   end
   assign bus.FAULT = fault_q;
`else
   assign tick_en = TICK;
   assign run     = 1'b1;
`endif

   assign req_ok     = bus.REQ_VALID && (int'(bus.REQ_FLOOR) < NUM_FLOORS);
   assign same_door  = req_ok && (state_q == ST_DOOR) && (bus.REQ_FLOOR == floor_q);
   assign can_step   = dir_q ? (int'(floor_q) < NUM_FLOORS - 1) : (floor_q != '0);
   assign step_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

   always_comb begin
      state_n  = state_q;
      floor_n  = floor_q;
      dir_n    = dir_q;
      move_n   = move_q;
      door_n   = door_q;
      arr_n    = 1'b0;
      clr_mask = '0;
      set_mask = (req_ok && !same_door) ? onehot(bus.REQ_FLOOR) : '0;

      if (tick_en) begin
         case (state_q)
            ST_IDLE: begin
               if ((pend_q & onehot(floor_q)) != '0) begin
                  clr_mask = onehot(floor_q);
                  state_n  = ST_DOOR;
                  door_n   = DOOR_LOAD;
               end else if (any_side(pend_q, floor_q, dir_q)) begin
                  state_n = ST_MOVE;
                  move_n  = MOVE_LOAD;
               end else if (any_side(pend_q, floor_q, !dir_q)) begin
                  dir_n   = !dir_q;
                  state_n = ST_MOVE;
                  move_n  = MOVE_LOAD;
               end
            end
            ST_MOVE: begin
               if (move_q != '0) begin
                  move_n = move_q - TW'(1);
               end else if (!can_step) begin
                  state_n = ST_IDLE;
               end else begin
                  // Arrival decision looks at the floor being entered, not the one left.
                  floor_n = step_floor;
                  arr_n   = 1'b1;
                  if ((pend_q & onehot(step_floor)) != '0) begin
                     clr_mask = onehot(step_floor);
                     state_n  = ST_DOOR;
                     door_n   = DOOR_LOAD;
                  end else if (any_side(pend_q, step_floor, dir_q)) begin
                     move_n = MOVE_LOAD;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end
            end
            ST_DOOR: begin
               if (bus.HOLD)            door_n  = DOOR_LOAD;
               else if (door_q != '0)   door_n  = door_q - TW'(1);
               else                     state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end

      // A call for the floor whose door is open keeps the door open instead of queueing.
      if (same_door && run) begin
         state_n = ST_DOOR;
         door_n  = DOOR_LOAD;
      end

      pend_n = (pend_q | set_mask) & ~clr_mask;
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         floor_q <= '0;
         dir_q   <= 1'b1;
         pend_q  <= '0;
         move_q  <= '0;
         door_q  <= '0;
         arr_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         floor_q <= floor_n;
         dir_q   <= dir_n;
         pend_q  <= pend_n;
         move_q  <= move_n;
         door_q  <= door_n;
         arr_q   <= arr_n;
      end
   end

   assign bus.FLOOR     = floor_q;
   assign bus.DIR_UP    = dir_q;
   assign bus.MOVING    = (state_q == ST_MOVE);
   assign bus.DOOR_OPEN = (state_q == ST_DOOR);
   assign bus.PENDING   = pend_q;
   assign bus.ARRIVED   = arr_q;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb/tb_elevator_ctrl_n.sv - self-checking bench for elevator_ctrl_n against a tick-level behavioural model
module tb_elevator_ctrl_n;
   localparam int NF = 7;
   localparam int FW = 3;
   localparam int MT = 4;
   localparam int DT = 3;

   logic CLOCK_50 = 1'b0;
   logic RESET;
   logic TICK;

   elevator_ctrl_n_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

   elevator_ctrl_n #(
      .NUM_FLOORS(NF), .FLOOR_W(FW), .MOVE_TICKS(MT), .DOOR_TICKS(DT)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RESET(RESET),
      .TICK(TICK),
      .bus(bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: mode 0 idle, 1 travelling, 2 door open; ticks_left counts ticks still to go.
   int m_floor, m_up, m_mode, m_left, m_arr;
   bit m_pend[NF];

   task automatic expect_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pend_word();
      int w = 0;
      for (int i = 0; i < NF; i++) if (m_pend[i]) w += (1 << i);
      return w;
   endfunction

   function automatic int count_side(input int f, input int up);
      int c = 0;
      for (int i = 0; i < NF; i++)
         if (m_pend[i] && ((up != 0) ? (i > f) : (i < f))) c++;
      return c;
   endfunction

   task automatic model_step(input bit rst, input bit tick, input bit rv, input int rf, input bit hold);
      int clr = -1;
      bit keep_door;
      if (rst) begin
         m_floor = 0; m_up = 1; m_mode = 0; m_left = 0; m_arr = 0;
         for (int i = 0; i < NF; i++) m_pend[i] = 0;
         return;
      end
      keep_door = (m_mode == 2) && rv && (rf == m_floor);
      m_arr = 0;
      if (tick) begin
         if (m_mode == 0) begin
            if (m_pend[m_floor]) begin
               clr = m_floor; m_mode = 2; m_left = DT;
            end else if (count_side(m_floor, m_up) > 0) begin
               m_mode = 1; m_left = MT;
            end else if (count_side(m_floor, 1 - m_up) > 0) begin
               m_up = 1 - m_up; m_mode = 1; m_left = MT;
            end
         end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
               if ((m_up != 0 && m_floor < NF - 1) || (m_up == 0 && m_floor > 0)) begin
                  m_floor += (m_up != 0) ? 1 : -1;
                  m_arr = 1;
                  if (m_pend[m_floor]) begin
                     clr = m_floor; m_mode = 2; m_left = DT;
                  end else if (count_side(m_floor, m_up) > 0) begin
                     m_left = MT;
                  end else begin
                     m_mode = 0;
                  end
               end else begin
                  m_mode = 0;
               end
            end
         end else begin
            if (hold) m_left = DT;
            else begin
               m_left--;
               if (m_left == 0) m_mode = 0;
            end
         end
      end
      if (keep_door) begin
         m_mode = 2; m_left = DT;
      end else if (rv && rf < NF) begin
         m_pend[rf] = 1;
      end
      if (clr >= 0) m_pend[clr] = 0;
   endtask

   task automatic compare_all();
      expect_eq("floor",     int'(bus.FLOOR),     m_floor);
      expect_eq("dir_up",    int'(bus.DIR_UP),    m_up);
      expect_eq("moving",    int'(bus.MOVING),    (m_mode == 1) ? 1 : 0);
      expect_eq("door_open", int'(bus.DOOR_OPEN), (m_mode == 2) ? 1 : 0);
      expect_eq("pending",   int'(bus.PENDING),   pend_word());
      expect_eq("arrived",   int'(bus.ARRIVED),   m_arr);
   endtask

   task automatic step(input bit rst, input bit tick, input bit rv, input int rf, input bit hold);
      @(negedge CLOCK_50);
      RESET         = rst;
      TICK          = tick;
      bus.REQ_VALID = rv;
      bus.REQ_FLOOR = rf[FW-1:0];
      bus.HOLD      = hold;
      @(posedge CLOCK_50);
      model_step(rst, tick, rv, rf, hold);
      #1;
      compare_all();
   endtask

   initial begin
      int ticks, t5, arrivals, door_cnt, found;
      bit prev_door;
      int doors[$];

      RESET = 1'b1; TICK = 1'b0;
      bus.REQ_VALID = 1'b0; bus.REQ_FLOOR = '0; bus.HOLD = 1'b0;
`ifdef ELEVATOR_ESTOP_EN
      bus.ESTOP = 1'b0;
`endif
      model_step(1'b1, 1'b0, 1'b0, 0, 1'b0);

      // Reset state, with TICK and a request asserted alongside RESET
      step(1, 1, 1, 3, 0);
      expect_eq("rst_floor",   int'(bus.FLOOR), 0);
      expect_eq("rst_dir",     int'(bus.DIR_UP), 1);
      expect_eq("rst_moving",  int'(bus.MOVING), 0);
      expect_eq("rst_door",    int'(bus.DOOR_OPEN), 0);
      expect_eq("rst_pending", int'(bus.PENDING), 0);

      // Single trip to floor 5 with TICK every cycle
      step(0, 0, 1, 5, 0);
      t5 = 0; arrivals = 0; door_cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         if (bus.DOOR_OPEN) door_cnt++;
         step(0, 1, 0, 0, 0);
         if (i == 1) expect_eq("move_on_first_tick", int'(bus.MOVING), 1);
         if (bus.ARRIVED) arrivals++;
         if (t5 == 0 && int'(bus.FLOOR) == 5) t5 = i;
      end
      expect_eq("tick_at_floor5", t5, 21);
      expect_eq("arrived_pulses", arrivals, 5);
      expect_eq("door_ticks",     door_cnt, DT);
      expect_eq("trip_pending",   int'(bus.PENDING), 0);
      expect_eq("trip_idle",      int'(bus.MOVING) + int'(bus.DOOR_OPEN), 0);

      // SCAN ordering
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 6, 0);
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         step(0, 1, 0, 0, 0);
         if (int'(bus.FLOOR) == 2 && bus.MOVING) found = 1;
      end
      expect_eq("scan_reach_floor2", found, 1);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 4, 0);
      prev_door = 1'b0;
      for (int i = 0; i < 120; i++) begin
         step(0, 1, 0, 0, 0);
         if (bus.DOOR_OPEN && !prev_door) doors.push_back(int'(bus.FLOOR));
         prev_door = bus.DOOR_OPEN;
      end
      expect_eq("scan_door_count", doors.size(), 3);
      if (doors.size() == 3) begin
         expect_eq("scan_door0", doors[0], 4);
         expect_eq("scan_door1", doors[1], 6);
         expect_eq("scan_door2", doors[2], 1);
      end
      expect_eq("scan_final_floor", int'(bus.FLOOR), 1);
      expect_eq("scan_dir_down",    int'(bus.DIR_UP), 0);
      expect_eq("scan_pending",     int'(bus.PENDING), 0);

      // Current-floor request in IDLE opens the door without travel, then HOLD
      step(0, 0, 1, 1, 0);
      step(0, 1, 0, 0, 0);
      expect_eq("here_door",   int'(bus.DOOR_OPEN), 1);
      expect_eq("here_floor",  int'(bus.FLOOR), 1);
      expect_eq("here_moving", int'(bus.MOVING), 0);
      door_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.DOOR_OPEN) door_cnt++;
         step(0, 1, 0, 0, (i < 5) ? 1'b1 : 1'b0);
      end
      expect_eq("hold_door_ticks", door_cnt, 5 + DT);

      // Same-floor request while the door is open reloads the dwell
      step(0, 0, 1, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      expect_eq("reload_pending", int'(bus.PENDING), 0);
      expect_eq("reload_door",    int'(bus.DOOR_OPEN), 1);
      door_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.DOOR_OPEN) door_cnt++;
         step(0, 1, 0, 0, 0);
      end
      expect_eq("reload_door_ticks", door_cnt, DT);

      // Out-of-range request ignored; requests accumulate without TICK
      step(0, 0, 1, 7, 0);
      expect_eq("oor_pending", int'(bus.PENDING), 0);
      step(0, 0, 1, 4, 0);
      for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
      expect_eq("notick_pending", int'(bus.PENDING), 16);
      expect_eq("notick_floor",   int'(bus.FLOOR), 1);

      // Reset in the middle of a trip
      step(0, 0, 1, 6, 0);
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         step(0, 1, 0, 0, 0);
         if (int'(bus.FLOOR) == 3 && bus.MOVING) found = 1;
      end
      expect_eq("midmove_reached", found, 1);
      expect_eq("midmove_pending", int'(bus.PENDING), 80);
      step(1, 1, 1, 2, 0);
      expect_eq("midrst_floor",   int'(bus.FLOOR), 0);
      expect_eq("midrst_pending", int'(bus.PENDING), 0);
      expect_eq("midrst_moving",  int'(bus.MOVING), 0);
      expect_eq("midrst_dir",     int'(bus.DIR_UP), 1);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 599) == 0,
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 5) == 0,
              int'($urandom_range(0, 7)),
              $urandom_range(0, 9) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
